// File: rtl/some_stream_buffer_if.sv
// Valid/ready stream bundle for some_stream_buffer.
// Carries both the upstream (in_*) and downstream (out_*) channels.
interface some_stream_buffer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Producer/consumer side driving the buffer
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

    // The buffer itself
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data
    );
endinterface

// File: rtl/some_stream_buffer.sv
// Circular first-word-fall-through FIFO with occupancy and peak tracking.
// Ready/valid are registered-state only: no comb path from in_* to out_*.
module some_stream_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    some_stream_buffer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   hwm
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, wr_ptr_next;
    logic [AW-1:0]    rd_ptr, rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    hwm_next;
    logic             push;
    logic             pop;

    // Handshake outputs derive from the state register only
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Storage write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // State, pointer, occupancy and peak registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hwm    <= '0;
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            hwm    <= hwm_next;
        end
    end

    // Next-state: pointers wrap naturally at power-of-2 depth; clr wins
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        hwm_next    = hwm;

        if (push) begin
            wr_ptr_next = wr_ptr + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end

        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_next = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop && count == C_LAST) begin
                    state_next = FULL;
                end else if (pop && !push && count == C_ONE) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next = PARTIAL;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        if (count_next > hwm) begin
            hwm_next = count_next;
        end

        if (clr) begin
            state_next  = EMPTY;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            hwm_next    = '0;
        end
    end
endmodule

// File: tb/tb_some_stream_buffer.sv
// Directed bench for some_stream_buffer (WIDTH=8, DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_some_stream_buffer;
    logic       clk;
    logic       rst;
    logic       clr;
    logic [2:0] count;
    logic [2:0] hwm;
    int         checks;
    int         failures;

    some_stream_buffer_if #(.WIDTH(8)) bus ();

    some_stream_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .bus   (bus.slave),
        .count (count),
        .hwm   (hwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h99;
        bus.out_ready = 1'b0;

        // 1: reset with in_valid held
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_hwm", 32'(hwm), 32'd0);
        bus.in_valid = 1'b0;
        step();

        // 2: fill to full, then a held 5th word
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h11 * (i + 1));
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_head", 32'(bus.out_data), 32'h11);
        end
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_hwm", 32'(hwm), 32'd4);
        bus.in_data = 8'h55;
        step();
        step();
        chk("full_hold_count", 32'(count), 32'd4);
        chk("full_hold_head", 32'(bus.out_data), 32'h11);
        bus.in_valid = 1'b0;

        // 3: drain
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_data", 32'(bus.out_data), 32'(8'h11 * (i + 1)));
            step();
        end
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_hwm", 32'(hwm), 32'd4);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        step();
        chk("empty_pop_count", 32'(count), 32'd0);
        bus.out_ready = 1'b0;

        // 4: steady push+pop at count=2 across pointer wraps
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hE0;
        step();
        bus.in_data  = 8'hE1;
        step();
        chk("pp_prefill", 32'(count), 32'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_data = 8'(k);
            chk("pp_head", 32'(bus.out_data),
                (k == 0) ? 32'hE0 : (k == 1) ? 32'hE1 : 32'(k - 2));
            step();
            chk("pp_count", 32'(count), 32'd2);
        end
        bus.in_valid = 1'b0;
        chk("pp_tail0", 32'(bus.out_data), 32'h08);
        step();
        chk("pp_tail1", 32'(bus.out_data), 32'h09);
        step();
        chk("pp_empty", 32'(bus.out_valid), 32'd0);
        chk("pp_hwm", 32'(hwm), 32'd4);
        bus.out_ready = 1'b0;

        // 5: clr beats simultaneous push and pop at count=3
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'(8'h31 + i);
            step();
        end
        chk("clr_pre_count", 32'(count), 32'd3);
        clr           = 1'b1;
        bus.in_data   = 8'h34;
        bus.out_ready = 1'b1;
        step();
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_hwm", 32'(hwm), 32'd0);
        chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_out_data", 32'(bus.out_data), 32'h00);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h35;
        step();
        bus.in_valid = 1'b0;
        chk("clr_after_data", 32'(bus.out_data), 32'h35);
        chk("clr_after_count", 32'(count), 32'd1);
        chk("clr_after_hwm", 32'(hwm), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("clr_after_drain", 32'(count), 32'd0);

        // 6: asynchronous reset mid-cycle at count=2
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h61;
        step();
        bus.in_data  = 8'h62;
        step();
        bus.in_valid = 1'b0;
        chk("arst_pre_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data", 32'(bus.out_data), 32'h00);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_hwm", 32'(hwm), 32'd0);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        step();
        bus.in_valid = 1'b0;
        chk("arst_push_data", 32'(bus.out_data), 32'hA5);
        chk("arst_push_count", 32'(count), 32'd1);
        chk("arst_push_hwm", 32'(hwm), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
